// File: rtl/serial_transmitter.sv
// Parallel-to-serial frame generator: 2-deep word buffer feeding a start/parity/7-data/stop
// frame serializer, one bit per clock, bit-exact with the lab serial receiver.
module serial_transmitter #(
    parameter bit          START_STOPN = 1'b0,
    parameter int unsigned GAP_CYCLES  = 0
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [6:0] data_in,
    input  logic       valid,
    input  logic       force_parity_error,
    output logic       ready,
    output logic       serial_out,
    output logic       busy,
    output logic       sent
);

    localparam logic       IDLE_LEVEL = ~START_STOPN;
    localparam bit         HAS_GAP    = (GAP_CYCLES != 0);
    localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);

    // The state names what is currently on the line, so busy decodes directly from it.
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_PARITY,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    state_t     state;
    logic [7:0] fifo_mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic [6:0] shift_data;
    logic       shift_err;
    logic [2:0] bit_idx;
    logic [3:0] gap_cnt;
    logic       push;
    logic       pop;
    logic       can_start;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        can_start = 1'b0;
        case (state)
            S_IDLE:  can_start = 1'b1;
            S_STOP:  can_start = !HAS_GAP;
            S_GAP:   can_start = (gap_cnt == 4'd0);
            default: can_start = 1'b0;
        endcase
        push = valid && ready;
        pop  = can_start && (count != 2'd0);
    end

    assign ready = (count != 2'd2);
    assign busy  = (state != S_IDLE);

    // NOTE: the buffer storage carries no reset; only the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {force_parity_error, data_in};
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= S_IDLE;
            serial_out <= IDLE_LEVEL;
            sent       <= 1'b0;
            shift_data <= 7'd0;
            shift_err  <= 1'b0;
            bit_idx    <= 3'd0;
            gap_cnt    <= 4'd0;
        end else begin
            sent <= 1'b0;
            if (pop) begin
                // A new frame may start from IDLE, straight out of STOP, or at the end of GAP.
                {shift_err, shift_data} <= fifo_mem[rd_ptr];
                serial_out              <= START_STOPN;
                gap_cnt                 <= 4'd0;
                state                   <= S_START;
            end else begin
                case (state)
                    S_IDLE: begin
                        serial_out <= IDLE_LEVEL;
                    end
                    S_START: begin
                        serial_out <= (^shift_data) ^ shift_err;
                        state      <= S_PARITY;
                    end
                    S_PARITY: begin
                        serial_out <= shift_data[0];
                        bit_idx    <= 3'd0;
                        state      <= S_DATA;
                    end
                    S_DATA: begin
                        if (bit_idx == 3'd6) begin
                            serial_out <= IDLE_LEVEL;
                            sent       <= 1'b1;
                            bit_idx    <= 3'd0;
                            state      <= S_STOP;
                        end else begin
                            serial_out <= shift_data[bit_idx + 3'd1];
                            bit_idx    <= bit_idx + 3'd1;
                        end
                    end
                    S_STOP: begin
                        serial_out <= IDLE_LEVEL;
                        if (HAS_GAP) begin
                            gap_cnt <= GAP_LOAD;
                            state   <= S_GAP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_GAP: begin
                        serial_out <= IDLE_LEVEL;
                        if (gap_cnt == 4'd0) begin
                            state <= S_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt - 4'd1;
                        end
                    end
                    default: begin
                        serial_out <= IDLE_LEVEL;
                        state      <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_transmitter.sv
// Bench for serial_transmitter: three instances (default, 3-cycle gap, inverted line) with a
// behavioural frame receiver per line checking every frame against a scoreboard queue.
module tb_serial_transmitter;

    logic       clk;
    logic       rstN;
    logic [6:0] data_in;
    logic       fpe;
    logic [2:0] valid_v;
    logic [2:0] ready_v;
    logic [2:0] so_v;
    logic [2:0] busy_v;
    logic [2:0] sent_v;

    int checks = 0;
    int errors = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    int         pos        [3];
    int         idle_run   [3];
    int         starts     [3];
    int         rx_count   [3];
    int         gap_hist   [3][256];
    logic [6:0] rx_data    [3];
    logic       rx_par     [3];
    logic [6:0] last_data  [3];
    logic       last_par   [3];
    logic       last_par_ok[3];

    serial_transmitter #(.START_STOPN(1'b0), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rstN(rstN), .data_in(data_in), .valid(valid_v[0]),
        .force_parity_error(fpe), .ready(ready_v[0]), .serial_out(so_v[0]),
        .busy(busy_v[0]), .sent(sent_v[0])
    );

    serial_transmitter #(.START_STOPN(1'b0), .GAP_CYCLES(3)) dut1 (
        .clk(clk), .rstN(rstN), .data_in(data_in), .valid(valid_v[1]),
        .force_parity_error(fpe), .ready(ready_v[1]), .serial_out(so_v[1]),
        .busy(busy_v[1]), .sent(sent_v[1])
    );

    serial_transmitter #(.START_STOPN(1'b1), .GAP_CYCLES(0)) dut2 (
        .clk(clk), .rstN(rstN), .data_in(data_in), .valid(valid_v[2]),
        .force_parity_error(fpe), .ready(ready_v[2]), .serial_out(so_v[2]),
        .busy(busy_v[2]), .sent(sent_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic idle_level(input int d);
        return (d == 2) ? 1'b0 : 1'b1;
    endfunction

    function automatic int q_size(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic q_push(input int d, input logic [7:0] v);
        case (d)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic q_pop(input int d, output logic [7:0] v, output bit ok);
        ok = (q_size(d) != 0);
        v  = 8'h00;
        if (ok) begin
            case (d)
                0:       v = q0.pop_front();
                1:       v = q1.pop_front();
                default: v = q2.pop_front();
            endcase
        end
    endtask

    task automatic q_flush(input int d);
        case (d)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    // Behavioural receiver: decodes each line and compares completed frames with the queue.
    task automatic monitor();
        logic       line;
        logic       sl;
        logic [7:0] e;
        bit         ok;
        logic       pok;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                line = so_v[d];
                sl   = ~idle_level(d);
                if (!rstN) begin
                    pos[d]      = 0;
                    idle_run[d] = 0;
                end else if (pos[d] == 0) begin
                    checks++;
                    if (sent_v[d] !== 1'b0)
                        $display("FAIL sent_outside_stop[%0d]: got %b expected 0", d, sent_v[d]);
                    if (sent_v[d] !== 1'b0) errors++;
                    if (line === sl) begin
                        gap_hist[d][starts[d] % 256] = idle_run[d];
                        starts[d]++;
                        pos[d] = 1;
                    end else begin
                        idle_run[d]++;
                    end
                end else begin
                    checks++;
                    if (sent_v[d] !== (pos[d] == 9)) begin
                        errors++;
                        $display("FAIL sent_bit%0d[%0d]: got %b expected %b", pos[d], d, sent_v[d], pos[d] == 9);
                    end
                    if (pos[d] == 1) begin
                        rx_par[d] = line;
                        pos[d]++;
                    end else if (pos[d] <= 8) begin
                        rx_data[d][pos[d] - 2] = line;
                        pos[d]++;
                    end else begin
                        checks++;
                        if (line !== ~sl) begin
                            errors++;
                            $display("FAIL stop_bit[%0d]: got %b expected %b", d, line, ~sl);
                        end
                        pok            = ((^rx_data[d]) == rx_par[d]);
                        last_data[d]   = rx_data[d];
                        last_par[d]    = rx_par[d];
                        last_par_ok[d] = pok;
                        rx_count[d]++;
                        q_pop(d, e, ok);
                        checks++;
                        if (!ok) begin
                            errors++;
                            $display("FAIL unexpected_frame[%0d]: got data %h expected no frame", d, rx_data[d]);
                        end else begin
                            if (rx_data[d] !== e[6:0]) begin
                                errors++;
                                $display("FAIL frame_data[%0d]: got %h expected %h", d, rx_data[d], e[6:0]);
                            end
                            checks++;
                            if (pok !== !e[7]) begin
                                errors++;
                                $display("FAIL frame_parity_ok[%0d]: got %b expected %b", d, pok, !e[7]);
                            end
                        end
                        pos[d]      = 0;
                        idle_run[d] = 0;
                    end
                end
            end
        end
    endtask

    // Called at a negedge; leaves valid asserted so consecutive calls hold it continuously.
    task automatic push_word(input int d, input logic [6:0] w, input logic err, output int stall);
        stall      = 0;
        data_in    = w;
        fpe        = err;
        valid_v[d] = 1'b1;
        while (ready_v[d] !== 1'b1 && stall < 200) begin
            @(negedge clk);
            stall++;
        end
        if (ready_v[d] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL push_timeout[%0d]: got ready %b expected 1", d, ready_v[d]);
        end else begin
            q_push(d, {err, w});
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while ((q_size(d) != 0 || busy_v[d] !== 1'b0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (q_size(d) != 0 || busy_v[d] !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout[%0d]: got %0d pending, busy %b expected 0 pending, busy 0",
                     d, q_size(d), busy_v[d]);
        end
    endtask

    task automatic test_reset();
        rstN    = 1'b1;
        valid_v = 3'b000;
        data_in = 7'd0;
        fpe     = 1'b0;
        #2 rstN = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (so_v[d] !== idle_level(d)) begin
                errors++;
                $display("FAIL reset_line[%0d]: got %b expected %b", d, so_v[d], idle_level(d));
            end
            checks++;
            if (ready_v[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready[%0d]: got %b expected 1", d, ready_v[d]);
            end
            checks++;
            if (busy_v[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy[%0d]: got %b expected 0", d, busy_v[d]);
            end
            checks++;
            if (sent_v[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_sent[%0d]: got %b expected 0", d, sent_v[d]);
            end
        end
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        logic [9:0] exp_bits;
        int         st;
        exp_bits = 10'b1101010100;
        push_word(0, 7'h55, 1'b0, st);
        valid_v[0] = 1'b0;
        checks++;
        if (so_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: got %b expected 1", so_v[0]);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (so_v[0] !== exp_bits[i]) begin
                errors++;
                $display("FAIL single_bit%0d: got %b expected %b", i, so_v[0], exp_bits[i]);
            end
            checks++;
            if (busy_v[0] !== 1'b1) begin
                errors++;
                $display("FAIL single_busy%0d: got %b expected 1", i, busy_v[0]);
            end
        end
        @(negedge clk);
        checks++;
        if (so_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_after_line: got %b expected 1", so_v[0]);
        end
        checks++;
        if (busy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_after_busy: got %b expected 0", busy_v[0]);
        end
        wait_idle(0);
    endtask

    task automatic test_parity();
        int st;
        for (int k = 0; k < 2; k++) begin
            push_word(0, 7'h7F, k[0], st);
            valid_v[0] = 1'b0;
            wait_idle(0);
            checks++;
            if (last_par[0] !== ~k[0]) begin
                errors++;
                $display("FAIL parity_bit_err%0d: got %b expected %b", k, last_par[0], ~k[0]);
            end
            checks++;
            if (last_par_ok[0] !== ~k[0]) begin
                errors++;
                $display("FAIL parity_ok_err%0d: got %b expected %b", k, last_par_ok[0], ~k[0]);
            end
            checks++;
            if (last_data[0] !== 7'h7F) begin
                errors++;
                $display("FAIL parity_data_err%0d: got %h expected 7f", k, last_data[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int st;
        int max_stall = 0;
        int s0        = starts[0];
        for (int w = 1; w <= 4; w++) begin
            push_word(0, 7'(w), 1'b0, st);
            if (st > max_stall) max_stall = st;
        end
        valid_v[0] = 1'b0;
        wait_idle(0);
        checks++;
        if (max_stall == 0) begin
            errors++;
            $display("FAIL backpressure_stall: got %0d stall cycles expected more than 0", max_stall);
        end
        checks++;
        if (starts[0] - s0 != 4) begin
            errors++;
            $display("FAIL burst_frames: got %0d expected 4", starts[0] - s0);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (gap_hist[0][(s0 + i) % 256] != 0) begin
                errors++;
                $display("FAIL burst_gap%0d: got %0d idle cycles expected 0", i, gap_hist[0][(s0 + i) % 256]);
            end
        end
    endtask

    task automatic test_gap();
        int st;
        int n     = 0;
        int nsent = 0;
        int s0    = starts[1];
        push_word(1, 7'h1C, 1'b0, st);
        push_word(1, 7'h63, 1'b0, st);
        valid_v[1] = 1'b0;
        while (nsent < 2 && n < 100) begin
            if (sent_v[1] === 1'b1) nsent++;
            if (nsent < 2) @(negedge clk);
            n++;
        end
        checks++;
        if (nsent != 2) begin
            errors++;
            $display("FAIL gap_sent_count: got %0d expected 2", nsent);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy_v[1] !== 1'b1 || so_v[1] !== 1'b1) begin
                errors++;
                $display("FAIL gap_cycle%0d: got busy %b line %b expected busy 1 line 1", i, busy_v[1], so_v[1]);
            end
        end
        @(negedge clk);
        checks++;
        if (busy_v[1] !== 1'b0) begin
            errors++;
            $display("FAIL gap_end_busy: got %b expected 0", busy_v[1]);
        end
        wait_idle(1);
        checks++;
        if (starts[1] - s0 != 2 || gap_hist[1][(s0 + 1) % 256] != 3) begin
            errors++;
            $display("FAIL gap_idle_cycles: got %0d frames, %0d idle expected 2 frames, 3 idle",
                     starts[1] - s0, gap_hist[1][(s0 + 1) % 256]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int st;
        int s0;
        push_word(0, 7'h2A, 1'b0, st);
        push_word(0, 7'h15, 1'b0, st);
        valid_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (so_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: got line %b busy %b expected line 0 busy 1", so_v[0], busy_v[0]);
        end
        #2 rstN = 1'b0;
        #1;
        checks++;
        if (so_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_line: got %b expected 1", so_v[0]);
        end
        checks++;
        if (ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_flags: got ready %b busy %b expected ready 1 busy 0", ready_v[0], busy_v[0]);
        end
        q_flush(0);
        @(negedge clk);
        rstN = 1'b1;
        s0   = starts[0];
        repeat (30) @(negedge clk);
        checks++;
        if (starts[0] != s0) begin
            errors++;
            $display("FAIL midreset_no_frame: got %0d frames expected 0", starts[0] - s0);
        end
        checks++;
        if (ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || so_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_after: got ready %b busy %b line %b expected 1 0 1",
                     ready_v[0], busy_v[0], so_v[0]);
        end
    endtask

    task automatic test_loopback();
        logic [6:0] words [3];
        int         st;
        int         c0 = rx_count[2];
        words[0] = 7'h00;
        words[1] = 7'h7F;
        words[2] = 7'h33;
        for (int i = 0; i < 3; i++) push_word(2, words[i], 1'b0, st);
        valid_v[2] = 1'b0;
        wait_idle(2);
        checks++;
        if (rx_count[2] - c0 != 3) begin
            errors++;
            $display("FAIL loopback_count: got %0d expected 3", rx_count[2] - c0);
        end
        checks++;
        if (last_data[2] !== 7'h33 || last_par_ok[2] !== 1'b1) begin
            errors++;
            $display("FAIL loopback_last: got %h ok %b expected 33 ok 1", last_data[2], last_par_ok[2]);
        end
        checks++;
        if (so_v[2] !== 1'b0) begin
            errors++;
            $display("FAIL loopback_idle_line: got %b expected 0", so_v[2]);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            pos[d]      = 0;
            idle_run[d] = 0;
            starts[d]   = 0;
            rx_count[d] = 0;
        end
        fork
            monitor();
        join_none
        test_reset();
        test_single_frame();
        test_parity();
        test_back_to_back();
        test_gap();
        test_reset_mid_frame();
        test_loopback();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
